l1_l2_read_arbiter: RTL and testbench

- Shares one L2 read port between the L1 I-cache refill path (M0) and the L1 D-cache refill path (M1).
- Round-robin arbitration with one outstanding transaction at a time.
- Latches the winner's AR request, issues it to L2, then steers the R burst back to the winner.
- Sits between l1_icache/l1_dcache and the L2 read channel, which is a flattened axi4_if read subset.

---
 rtl/l1_l2_read_arbiter.sv | 167 ++++++++++++++++
 tb/tb_l1_l2_read_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/l1_l2_read_arbiter.sv
// l1_l2_read_arbiter: shares one L2 read port between the L1 I-cache (M0)
// and L1 D-cache (M1) refill paths. Round-robin arbitration, one
// outstanding burst at a time. The winner's request is latched, issued
// to L2, and the R burst is steered back to the winner.
// Optional build macro: L1_L2_ARB_PERF_CNT_EN adds saturating grant and
// wait performance counters.
module l1_l2_read_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_arvalid,
  input  logic                  m1_arvalid,
  output logic                  m0_arready,
  output logic                  m1_arready,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic [LEN_WIDTH-1:0]  m0_arlen,
  input  logic [LEN_WIDTH-1:0]  m1_arlen,
  output logic                  m0_rvalid,
  output logic                  m1_rvalid,
  input  logic                  m0_rready,
  input  logic                  m1_rready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m0_rlast,
  output logic                  m1_rlast,
  output logic                  l2_arvalid,
  input  logic                  l2_arready,
  output logic [ADDR_WIDTH-1:0] l2_araddr,
  output logic [LEN_WIDTH-1:0]  l2_arlen,
  input  logic                  l2_rvalid,
  output logic                  l2_rready,
  input  logic [DATA_WIDTH-1:0] l2_rdata,
  input  logic                  l2_rlast,
  output logic                  busy,
  output logic                  err_beat
`ifdef L1_L2_ARB_PERF_CNT_EN
  ,
  output logic [31:0]           grant_cnt_m0,
  output logic [31:0]           grant_cnt_m1,
  output logic [31:0]           wait_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t               state;
  state_t               state_next;
  logic                 rr_last;
  logic                 grant;
  logic [LEN_WIDTH:0]   beat_cnt;
  logic                 win;
  logic                 accept;
  logic                 in_data;
  logic                 r_hs;
  logic                 beat_err;

  // Pick a winner in IDLE; on a tie the master that did not win last time goes.
  always_comb begin
    win    = 1'b0;
    accept = 1'b0;
    if (state == IDLE) begin
      accept = m0_arvalid | m1_arvalid;
      if (m0_arvalid && m1_arvalid) begin
        win = ~rr_last;
      end else begin
        win = m1_arvalid;
      end
    end
    m0_arready = accept & ~win;
    m1_arready = accept & win;
  end

  // Steer the L2 read beat to the granted master only while in DATA.
  always_comb begin
    in_data   = (state == DATA);
    m0_rvalid = in_data & ~grant & l2_rvalid;
    m1_rvalid = in_data & grant & l2_rvalid;
    m0_rlast  = in_data & ~grant & l2_rlast;
    m1_rlast  = in_data & grant & l2_rlast;
    m0_rdata  = (in_data && !grant) ? l2_rdata : '0;
    m1_rdata  = (in_data && grant) ? l2_rdata : '0;
    l2_rready = in_data & (grant ? m1_rready : m0_rready);
    r_hs      = l2_rvalid & l2_rready;
    busy      = (state != IDLE);
    beat_err  = 1'b0;
    if (r_hs) begin
      if (l2_rlast) begin
        beat_err = (beat_cnt != {1'b0, l2_arlen});
      end else begin
        beat_err = (beat_cnt == {1'b0, l2_arlen});
      end
    end
  end

  // Next-state logic for the single-outstanding-transaction FSM.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ADDR;
      ADDR:    if (l2_arvalid && l2_arready) state_next = DATA;
      DATA:    if (r_hs && l2_rlast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, request latch, L2 request valid and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_last    <= 1'b1;
      grant      <= 1'b0;
      l2_arvalid <= 1'b0;
      l2_araddr  <= '0;
      l2_arlen   <= '0;
      beat_cnt   <= '0;
      err_beat   <= 1'b0;
    end else begin
      state    <= state_next;
      err_beat <= beat_err;
      if (accept) begin
        grant      <= win;
        rr_last    <= win;
        l2_araddr  <= win ? m1_araddr : m0_araddr;
        l2_arlen   <= win ? m1_arlen : m0_arlen;
        l2_arvalid <= 1'b1;
      end else if (state == ADDR && l2_arready) begin
        l2_arvalid <= 1'b0;
      end
      if (accept) begin
        beat_cnt <= '0;
      end else if (r_hs && beat_cnt != '1) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

`ifdef L1_L2_ARB_PERF_CNT_EN
  logic [1:0] stall_n;

  // Number of masters stalled this cycle (requesting but not accepted).
  always_comb begin
    stall_n = {1'b0, m0_arvalid & ~m0_arready} + {1'b0, m1_arvalid & ~m1_arready};
  end

  // Saturating grant and wait counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_m0 <= '0;
      grant_cnt_m1 <= '0;
      wait_cnt     <= '0;
    end else begin
      if (m0_arready && grant_cnt_m0 != '1) grant_cnt_m0 <= grant_cnt_m0 + 32'd1;
      if (m1_arready && grant_cnt_m1 != '1) grant_cnt_m1 <= grant_cnt_m1 + 32'd1;
      if (wait_cnt > (32'hFFFF_FFFF - {30'b0, stall_n})) begin
        wait_cnt <= '1;
      end else begin
        wait_cnt <= wait_cnt + {30'b0, stall_n};
      end
    end
  end
`endif

endmodule

// File: tb/tb_l1_l2_read_arbiter.sv
// Directed testbench for l1_l2_read_arbiter: reset state, single request,
// round-robin alternation, mid-burst backpressure, short burst error and
// reset in the middle of a burst.
module tb_l1_l2_read_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [63:0]  m0_araddr, m1_araddr;
  logic [7:0]   m0_arlen, m1_arlen;
  logic         m0_rvalid, m1_rvalid, m0_rready, m1_rready;
  logic [511:0] m0_rdata, m1_rdata;
  logic         m0_rlast, m1_rlast;
  logic         l2_arvalid, l2_arready;
  logic [63:0]  l2_araddr;
  logic [7:0]   l2_arlen;
  logic         l2_rvalid, l2_rready;
  logic [511:0] l2_rdata;
  logic         l2_rlast;
  logic         busy, err_beat;
`ifdef L1_L2_ARB_PERF_CNT_EN
  logic [31:0]  grant_cnt_m0, grant_cnt_m1, wait_cnt;
`endif

  int tests = 0;
  int failures = 0;

  l1_l2_read_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m1_arvalid(m1_arvalid),
    .m0_arready(m0_arready), .m1_arready(m1_arready),
    .m0_araddr(m0_araddr), .m1_araddr(m1_araddr),
    .m0_arlen(m0_arlen), .m1_arlen(m1_arlen),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rready(m0_rready), .m1_rready(m1_rready),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_rlast(m0_rlast), .m1_rlast(m1_rlast),
    .l2_arvalid(l2_arvalid), .l2_arready(l2_arready),
    .l2_araddr(l2_araddr), .l2_arlen(l2_arlen),
    .l2_rvalid(l2_rvalid), .l2_rready(l2_rready),
    .l2_rdata(l2_rdata), .l2_rlast(l2_rlast),
    .busy(busy), .err_beat(err_beat)
`ifdef L1_L2_ARB_PERF_CNT_EN
    , .grant_cnt_m0(grant_cnt_m0), .grant_cnt_m1(grant_cnt_m1), .wait_cnt(wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    m0_arvalid = 0; m1_arvalid = 0; l2_arready = 0;
    l2_rvalid = 0; l2_rlast = 0; l2_rdata = '0;
    m0_rready = 1; m1_rready = 1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One full transaction: acceptance in IDLE, ADDR phase with arGap wait
  // cycles, then nbeats beats (rlast on the final one), optionally stalling
  // the winner's rready for stallCycles before beat 1.
  task automatic applyStimulus(input bit win, input logic [63:0] addr, input logic [7:0] len,
                               input int nbeats, input int arGap, input int stallCycles,
                               input bit keep, input bit expErr, input logic [31:0] seed);
    logic [31:0] w;
    #1;
    checkOutput("arready_win", win ? m1_arready : m0_arready, 1);
    checkOutput("arready_lose", win ? m0_arready : m1_arready, 0);
    tick();
    if (!keep) begin
      if (win) m1_arvalid = 0; else m0_arvalid = 0;
    end
    #1;
    checkOutput("l2_arvalid", l2_arvalid, 1);
    checkOutput("l2_araddr", l2_araddr, addr);
    checkOutput("l2_arlen", l2_arlen, len);
    checkOutput("busy_addr", busy, 1);
    checkOutput("arready_addr", m0_arready | m1_arready, 0);
    repeat (arGap) begin
      tick();
      checkOutput("arvalid_hold", l2_arvalid, 1);
      checkOutput("araddr_hold", l2_araddr, addr);
    end
    l2_arready = 1;
    tick();
    l2_arready = 0;
    checkOutput("arvalid_clear", l2_arvalid, 0);
    for (int b = 0; b < nbeats; b++) begin
      w = seed + b;
      l2_rdata  = {16{w}};
      l2_rvalid = 1;
      l2_rlast  = (b == nbeats - 1);
      if (b == 1) begin
        repeat (stallCycles) begin
          if (win) m1_rready = 0; else m0_rready = 0;
          #1;
          checkOutput("l2_rready_stall", l2_rready, 0);
          checkOutput("rvalid_stall", win ? m1_rvalid : m0_rvalid, 1);
          tick();
        end
        m0_rready = 1; m1_rready = 1;
      end
      #1;
      checkOutput("rvalid_win", win ? m1_rvalid : m0_rvalid, 1);
      checkOutput("rdata_win", win ? m1_rdata : m0_rdata, {16{w}});
      checkOutput("rlast_win", win ? m1_rlast : m0_rlast, (b == nbeats - 1));
      checkOutput("rvalid_lose", win ? m0_rvalid : m1_rvalid, 0);
      checkOutput("rdata_lose", win ? m0_rdata : m1_rdata, 0);
      checkOutput("l2_rready", l2_rready, 1);
      tick();
    end
    l2_rvalid = 0;
    l2_rlast  = 0;
    #1;
    checkOutput("busy_done", busy, 0);
    checkOutput("err_beat", err_beat, expErr);
    checkOutput("beat_cnt", dut.beat_cnt, nbeats);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    m0_araddr = '0; m1_araddr = '0; m0_arlen = '0; m1_arlen = '0;
    doReset();

    // Reset state; a stray L2 beat in IDLE must be ignored.
    l2_rvalid = 1;
    #1;
    checkOutput("rst_arvalid", l2_arvalid, 0);
    checkOutput("rst_araddr", l2_araddr, 0);
    checkOutput("rst_arlen", l2_arlen, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err_beat, 0);
    checkOutput("rst_arready", {m0_arready, m1_arready}, 0);
    checkOutput("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    checkOutput("rst_l2_rready", l2_rready, 0);
    l2_rvalid = 0;

    // M0 only, single beat, L2 accepts after 2 wait cycles.
    m0_araddr = 64'h1000; m0_arlen = 0; m0_arvalid = 1;
    applyStimulus(0, 64'h1000, 8'd0, 1, 2, 0, 0, 0, 32'hA5A5A5A5);

    // Both masters request continuously: strict alternation M0, M1, M0, M1.
    doReset();
    m0_araddr = 64'h2000; m0_arlen = 3; m1_araddr = 64'h3000; m1_arlen = 3;
    m0_arvalid = 1; m1_arvalid = 1;
    applyStimulus(0, 64'h2000, 8'd3, 4, 0, 0, 1, 0, 32'h20000000);
    applyStimulus(1, 64'h3000, 8'd3, 4, 0, 0, 1, 0, 32'h30000000);
    applyStimulus(0, 64'h2000, 8'd3, 4, 0, 0, 1, 0, 32'h20001000);
    applyStimulus(1, 64'h3000, 8'd3, 4, 0, 0, 1, 0, 32'h30001000);

    // M1 alone with rready held low for 3 cycles mid-burst.
    m0_arvalid = 0;
    applyStimulus(1, 64'h3000, 8'd3, 4, 1, 3, 0, 0, 32'h31110000);

    // len 3 but rlast arrives on the third beat: error pulse, then cleared.
    m0_araddr = 64'h4000; m0_arlen = 3; m0_arvalid = 1;
    applyStimulus(0, 64'h4000, 8'd3, 3, 0, 0, 0, 1, 32'h40000000);
    tick();
    checkOutput("err_beat_clear", err_beat, 0);
    checkOutput("busy_after_err", busy, 0);

    // Reset in DATA after one of four beats.
    m0_araddr = 64'h5000; m0_arlen = 3; m0_arvalid = 1;
    #1;
    checkOutput("t5_arready", m0_arready, 1);
    tick();
    m0_arvalid = 0;
    l2_arready = 1;
    tick();
    l2_arready = 0;
    l2_rvalid = 1; l2_rlast = 0; l2_rdata = {16{32'h55555555}};
    tick();
    rst = 1;
    tick();
    rst = 0;
    checkOutput("t5_arvalid", l2_arvalid, 0);
    checkOutput("t5_l2_rready", l2_rready, 0);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_m0_rvalid", m0_rvalid, 0);
    l2_rvalid = 0;
    m1_araddr = 64'h6000; m0_arvalid = 1; m1_arvalid = 1;
    #1;
    checkOutput("t5_m0_first", m0_arready, 1);
    checkOutput("t5_m1_held", m1_arready, 0);
    tick();
    checkOutput("t5_araddr", l2_araddr, 64'h5000);
    m0_arvalid = 0; m1_arvalid = 0;

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
